// File: rtl/serial_subtractor_15bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_15bit
//
// Bit-serial two's-complement subtractor: D = X - Y - Bin, one bit per clock,
// LSB first. A single full-subtractor cell is time-shared across all bit
// positions. Operand shift registers feed it, and a result shift register
// collects its output.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request an operation (only honoured in IDLE)
//   X, Y       minuend / subtrahend, latched on the accepting edge
//   Bin        borrow-in, latched on the accepting edge
//   busy       high while bits are being processed (RUN)
//   done       one-cycle pulse when Dout/Bout/Underflow have just updated
//   Dout       difference modulo 2^WIDTH
//   Bout       borrow out of the MSB (unsigned X < Y + Bin)
//   Underflow  signed overflow (borrow into MSB xor borrow out of MSB)
// ---------------------------------------------------------------------------
module serial_subtractor_15bit #(
  parameter int WIDTH = 15,  // operand/result width, >= 2
  parameter int CNT_W = 4    // bit counter width, 2^CNT_W >= WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Dout,
  output logic             Bout,
  output logic             Underflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PEN_BIT  = CNT_W'(WIDTH - 2);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] x_sh_reg;
  logic [WIDTH-1:0] y_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             b_reg;     // running borrow into the current bit
  logic             bmsb_reg;  // borrow into the MSB, kept for overflow
  logic [WIDTH-1:0] dout_reg;
  logic             bout_reg;
  logic             uf_reg;

  // Shared full-subtractor cell
  logic xi, yi, di, b_next;

  assign xi     = x_sh_reg[0];
  assign yi     = y_sh_reg[0];
  assign di     = xi ^ yi ^ b_reg;
  assign b_next = (~xi & yi) | (~(xi ^ yi) & b_reg);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Published results (dout/bout/uf) are written only on the
  // edge that processes the MSB, so partial sums never reach the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_sh_reg <= '0;
      y_sh_reg <= '0;
      res_reg  <= '0;
      cnt_reg  <= '0;
      b_reg    <= 1'b0;
      bmsb_reg <= 1'b0;
      dout_reg <= '0;
      bout_reg <= 1'b0;
      uf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_sh_reg <= X;
            y_sh_reg <= Y;
            b_reg    <= Bin;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          x_sh_reg <= {1'b0, x_sh_reg[WIDTH-1:1]};
          y_sh_reg <= {1'b0, y_sh_reg[WIDTH-1:1]};
          // Result enters at the MSB; after WIDTH shifts bit 0 holds the LSB
          res_reg  <= {di, res_reg[WIDTH-1:1]};
          b_reg    <= b_next;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (cnt_reg == PEN_BIT) begin
            bmsb_reg <= b_next;
          end
          if (cnt_reg == LAST_BIT) begin
            dout_reg <= {di, res_reg[WIDTH-1:1]};
            bout_reg <= b_next;
            // bmsb_reg was captured on the previous edge (WIDTH >= 2)
            uf_reg   <= bmsb_reg ^ b_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Decoded from state so they drop together with an asynchronous reset
  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign Dout      = dout_reg;
  assign Bout      = bout_reg;
  assign Underflow = uf_reg;

endmodule

// File: tb/tb_serial_subtractor_15bit.sv
// Testbench for serial_subtractor_15bit: directed vector table, handshake
// and reset corner sequences, and a randomised sweep against an arithmetic
// reference model.
module tb_serial_subtractor_15bit;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Dout;
  logic         Bout;
  logic         Underflow;

  int n_checks = 0;
  int n_errors = 0;

  // Last published result the bench expects the DUT to be holding
  logic [W-1:0] hold_d;
  logic         hold_bo;
  logic         hold_uf;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         uf;
  } vec_t;

  vec_t vecs[9];

  serial_subtractor_15bit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .X         (X),
    .Y         (Y),
    .Bin       (Bin),
    .busy      (busy),
    .done      (done),
    .Dout      (Dout),
    .Bout      (Bout),
    .Underflow (Underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the unsigned and signed
  // interpretations of the operands.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic uf);
    int ud;
    int sd;
    int sx;
    int sy;
    ud = int'(x) - int'(y) - int'(bin);
    d  = ud[W-1:0];
    bo = (ud < 0);
    sx = (x[W-1]) ? int'(x) - (1 << W) : int'(x);
    sy = (y[W-1]) ? int'(y) - (1 << W) : int'(y);
    sd = sx - sy - int'(bin);
    uf = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
  endtask

  // Issue one operation, observe it to completion, and compare.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bin, input logic [W-1:0] ed, input logic ebo,
                       input logic euf);
    int  busy_cycles;
    int  done_cycle;
    bit  timed_out;
    bit  unstable;
    logic [W-1:0] d;
    logic bo;
    logic uf;
    @(negedge clk);
    X = x; Y = y; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0; done_cycle = 0; timed_out = 1'b1; unstable = 1'b0;
    d = '0; bo = 1'b0; uf = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        done_cycle = c;
        d = Dout; bo = Bout; uf = Underflow;
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
      if (Dout !== hold_d || Bout !== hold_bo || Underflow !== hold_uf) unstable = 1'b1;
      @(negedge clk);
    end
    check({tag, " timeout"}, 32'(timed_out), 32'd0);
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'd15);
    check({tag, " done_cycle"}, 32'(done_cycle), 32'd16);
    check({tag, " hold_during_run"}, 32'(unstable), 32'd0);
    check({tag, " Dout"}, 32'(d), 32'(ed));
    check({tag, " Bout"}, 32'(bo), 32'(ebo));
    check({tag, " Underflow"}, 32'(uf), 32'(euf));
    $display("%s: X=%h Y=%h Bin=%0d -> Dout=%h Bout=%0d Uf=%0d (exp %h %0d %0d)",
             tag, x, y, bin, d, bo, uf, ed, ebo, euf);
    hold_d = ed; hold_bo = ebo; hold_uf = euf;
  endtask

  initial begin
    int done_cnt;
    int done_at[3];
    logic [W-1:0] cap_d;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rb;
    logic [W-1:0] ed;
    logic         ebo;
    logic         euf;

    vecs[0] = '{15'd100,    15'd37,     1'b0, 15'd63,     1'b0, 1'b0};
    vecs[1] = '{15'h0000,   15'h0001,   1'b0, 15'h7FFF,   1'b1, 1'b0};
    vecs[2] = '{15'd5,      15'd5,      1'b1, 15'h7FFF,   1'b1, 1'b0};
    vecs[3] = '{15'h4000,   15'h0001,   1'b0, 15'h3FFF,   1'b0, 1'b1};
    vecs[4] = '{15'h3FFF,   15'h7FFF,   1'b0, 15'h4000,   1'b1, 1'b1};
    vecs[5] = '{15'h7FFF,   15'h7FFF,   1'b0, 15'h0000,   1'b0, 1'b0};
    vecs[6] = '{15'h0000,   15'h0000,   1'b1, 15'h7FFF,   1'b1, 1'b0};
    vecs[7] = '{15'h7FFF,   15'h0000,   1'b0, 15'h7FFF,   1'b0, 1'b0};
    vecs[8] = '{15'h0000,   15'h4000,   1'b0, 15'h4000,   1'b1, 1'b1};

    // Reset state
    reset = 1'b1; start = 1'b0; X = '0; Y = '0; Bin = 1'b0;
    hold_d = '0; hold_bo = 1'b0; hold_uf = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset Dout", 32'(Dout), 32'd0);
    check("reset Bout", 32'(Bout), 32'd0);
    check("reset Underflow", 32'(Underflow), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle done", 32'(done), 32'd0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].bin,
            vecs[i].d, vecs[i].bo, vecs[i].uf);
    end

    // Handshake robustness: extra start pulses and operand changes mid-run
    @(negedge clk);
    X = 15'd100; Y = 15'd37; Bin = 1'b0; start = 1'b1;
    done_cnt = 0; cap_d = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        cap_d = Dout;
        check("hs done_cycle", 32'(c), 32'd16);
        check("hs Bout", 32'(Bout), 32'd0);
        check("hs Underflow", 32'(Underflow), 32'd0);
      end
      start = (c == 3 || c == 15);
      if (c == 5) begin
        X = W'($urandom); Y = W'($urandom); Bin = 1'b1;
      end
    end
    check("hs done_count", 32'(done_cnt), 32'd1);
    check("hs Dout", 32'(cap_d), 32'd63);
    check("hs idle_after", 32'(busy), 32'd0);
    $display("handshake: done pulses=%0d Dout=%0d", done_cnt, cap_d);
    hold_d = 15'd63; hold_bo = 1'b0; hold_uf = 1'b0;

    // Back-to-back with start held high
    @(negedge clk);
    X = 15'd500; Y = 15'd20; Bin = 1'b1; start = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 80 && done_cnt < 3; c++) begin
      @(negedge clk);
      if (done) begin
        done_at[done_cnt] = c;
        done_cnt++;
        check("b2b Dout", 32'(Dout), 32'd479);
        if (done_cnt == 3) start = 1'b0;
      end
    end
    check("b2b done_count", 32'(done_cnt), 32'd3);
    if (done_cnt == 3) begin
      check("b2b gap1", 32'(done_at[1] - done_at[0]), 32'd17);
      check("b2b gap2", 32'(done_at[2] - done_at[1]), 32'd17);
      $display("back-to-back: done at %0d %0d %0d", done_at[0], done_at[1], done_at[2]);
    end
    hold_d = 15'd479; hold_bo = 1'b0; hold_uf = 1'b0;

    // Make published outputs all non-zero before the reset abort
    do_op("pre_reset", 15'h3FFF, 15'h7FFF, 1'b0, 15'h4000, 1'b1, 1'b1);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    X = 15'd200; Y = 15'd50; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);  // now in run cycle 7
    #2 reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort Dout", 32'(Dout), 32'd0);
    check("abort Bout", 32'(Bout), 32'd0);
    check("abort Underflow", 32'(Underflow), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    $display("reset abort: outputs cleared, done pulses=%0d", done_cnt);
    hold_d = '0; hold_bo = 1'b0; hold_uf = 1'b0;
    do_op("post_reset", 15'd1000, 15'd1, 1'b0, 15'd999, 1'b0, 1'b0);

    // Randomised sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      rx = W'($urandom); ry = W'($urandom); rb = 1'($urandom);
      if (i == 0) ry = rx;
      if (i == 1) ry = '0;
      if (i == 2) begin rx = 15'h7FFF; ry = 15'h7FFF; end
      model(rx, ry, rb, ed, ebo, euf);
      do_op($sformatf("rnd%0d", i), rx, ry, rb, ed, ebo, euf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
